// File: rtl/lfsr_if.sv
// LFSR control/data bundle: enable, seed load and compare value in,
// register state and sequence-match flag out. Clock and reset stay as
// plain module ports.
interface lfsr_if #(
    parameter int NUM_BITS = 4
);
    logic                i_Enable;
    logic                i_Seed_DV;
    logic [NUM_BITS-1:0] i_Seed_Data;
    logic [NUM_BITS-1:0] o_LFSR_Data;
    logic                o_LFSR_Done;

    // Driver side (testbench or surrounding logic)
    modport master (
        output i_Enable,
        output i_Seed_DV,
        output i_Seed_Data,
        input  o_LFSR_Data,
        input  o_LFSR_Done
    );

    // LFSR side
    modport slave (
        input  i_Enable,
        input  i_Seed_DV,
        input  i_Seed_Data,
        output o_LFSR_Data,
        output o_LFSR_Done
    );
endinterface

// File: rtl/lfsr.sv
// Maximal-length XNOR LFSR, NUM_BITS = 3..32, shifting toward the MSB with
// feedback entering bit 0. Seed load has priority over stepping; reset is
// synchronous and active-high and clears the register to all-zeros (a legal
// state for XNOR feedback).
//
// Optional feature: define LFSR_LOCKUP_RECOVER_EN to make an enabled step
// from the all-ones lockup state go to all-zeros. Without it the register
// stays at all-ones until reset or reseed.
module lfsr #(
    parameter int NUM_BITS = 4
) (
    input  logic  i_Clk,
    input  logic  i_Rst,
    lfsr_if.slave bus
);

    // Feedback tap mask per width; tap k (1-based) maps to bit k-1.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            3:       tap_mask = 32'h0000_0006;
            4:       tap_mask = 32'h0000_000C;
            5:       tap_mask = 32'h0000_0014;
            6:       tap_mask = 32'h0000_0030;
            7:       tap_mask = 32'h0000_0060;
            8:       tap_mask = 32'h0000_00B8;
            9:       tap_mask = 32'h0000_0110;
            10:      tap_mask = 32'h0000_0240;
            11:      tap_mask = 32'h0000_0500;
            12:      tap_mask = 32'h0000_0829;
            13:      tap_mask = 32'h0000_100D;
            14:      tap_mask = 32'h0000_2015;
            15:      tap_mask = 32'h0000_6000;
            16:      tap_mask = 32'h0000_D008;
            17:      tap_mask = 32'h0001_2000;
            18:      tap_mask = 32'h0002_0400;
            19:      tap_mask = 32'h0004_0023;
            20:      tap_mask = 32'h0009_0000;
            21:      tap_mask = 32'h0014_0000;
            22:      tap_mask = 32'h0030_0000;
            23:      tap_mask = 32'h0042_0000;
            24:      tap_mask = 32'h00E1_0000;
            25:      tap_mask = 32'h0120_0000;
            26:      tap_mask = 32'h0200_0023;
            27:      tap_mask = 32'h0400_0013;
            28:      tap_mask = 32'h0900_0000;
            29:      tap_mask = 32'h1400_0000;
            30:      tap_mask = 32'h2000_0029;
            31:      tap_mask = 32'h4800_0000;
            32:      tap_mask = 32'h8020_0003;
            default: tap_mask = 32'h0000_0000;
        endcase
    endfunction

    // Reject widths outside the supported tap table at elaboration.
    if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
        $error("lfsr: NUM_BITS=%0d outside legal range 3..32", NUM_BITS);
    end

    localparam logic [31:0]         TAP_MASK_FULL = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAP_MASK      = TAP_MASK_FULL[NUM_BITS-1:0];

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam bit LOCKUP_RECOVER = 1'b1;
`else
    localparam bit LOCKUP_RECOVER = 1'b0;
`endif

    logic [NUM_BITS-1:0] lfsr_q;
    logic [NUM_BITS-1:0] lfsr_d;
    logic                fb;
    logic                lockup;

    // Next-state selection: seed load beats stepping, otherwise hold.
    always_comb begin
        // Every tap list has an even number of taps, so the chained XNOR
        // reduces to the inverted parity of the tapped bits.
        fb     = ~^(lfsr_q & TAP_MASK);
        lockup = (lfsr_q == {NUM_BITS{1'b1}});
        lfsr_d = lfsr_q;
        if (bus.i_Seed_DV) begin
            lfsr_d = bus.i_Seed_Data;
        end else if (bus.i_Enable) begin
            if (LOCKUP_RECOVER && lockup) begin
                lfsr_d = '0;
            end else begin
                lfsr_d = {lfsr_q[NUM_BITS-2:0], fb};
            end
        end
    end

    // State register with synchronous reset to all-zeros.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bus.o_LFSR_Data = lfsr_q;
    // Match flag follows the seed input combinationally and ignores enable.
    assign bus.o_LFSR_Done = (lfsr_q == bus.i_Seed_Data);

endmodule

// File: tb/tb_lfsr.sv
// Directed testbench for lfsr: N=4 sequence, hold, seed, priority and
// lockup cases; N=32 first steps; full-period walk for N=3..14.
module tb_lfsr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Main N=4 instance
    lfsr_if #(.NUM_BITS(4)) m_if ();
    lfsr #(.NUM_BITS(4)) u_dut4 (.i_Clk(clk), .i_Rst(rst), .bus(m_if.slave));

    // N=32 instance for the widest tap set
    lfsr_if #(.NUM_BITS(32)) w_if ();
    lfsr #(.NUM_BITS(32)) u_dut32 (.i_Clk(clk), .i_Rst(rst), .bus(w_if.slave));

    // Period walk instances for N=3..14
    logic per_rst  = 1'b1;
    logic per_en   = 1'b0;
    logic per_run  = 1'b0;
    logic per_done = 1'b0;

    for (genvar g = 3; g <= 14; g++) begin : g_per
        lfsr_if #(.NUM_BITS(g)) p_if ();
        lfsr #(.NUM_BITS(g)) u_p (.i_Clk(clk), .i_Rst(per_rst), .bus(p_if.slave));
        assign p_if.i_Enable    = per_en;
        assign p_if.i_Seed_DV   = 1'b0;
        assign p_if.i_Seed_Data = '0;

        int steps = 0;
        int first = 0;
        bit hit   = 1'b0;
        bit rep   = 1'b0;
        bit seen [1 << g];

        always @(negedge clk) begin
            if (per_run) begin
                steps++;
                if (!hit) begin
                    if (p_if.o_LFSR_Data == '0) begin
                        hit   = 1'b1;
                        first = steps;
                    end else begin
                        if (seen[p_if.o_LFSR_Data]) rep = 1'b1;
                        seen[p_if.o_LFSR_Data] = 1'b1;
                    end
                end
            end
        end

        initial begin
            wait (per_done == 1'b1);
            chk($sformatf("period_n%0d", g), 64'(first), 64'((1 << g) - 1));
            chk($sformatf("norepeat_n%0d", g), 64'(rep), 64'd0);
        end
    end

    logic [3:0]  exp4 [15];
    logic [31:0] exp32 [4];
    int          done_cnt;

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        exp4 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                 4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
        exp32 = '{32'h1, 32'h2, 32'h4, 32'h9};

        m_if.i_Enable    = 1'b0;
        m_if.i_Seed_DV   = 1'b0;
        m_if.i_Seed_Data = 4'h0;
        w_if.i_Enable    = 1'b0;
        w_if.i_Seed_DV   = 1'b0;
        w_if.i_Seed_Data = 32'h0;
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_data", m_if.o_LFSR_Data, 4'h0);
        chk("rst_done", m_if.o_LFSR_Done, 1'b1);
        chk("rst_data32", w_if.o_LFSR_Data, 32'h0);

        // N=32 first steps while the N=4 instance holds at zero
        rst = 1'b0;
        w_if.i_Enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("n32_step%0d", i + 1), w_if.o_LFSR_Data, exp32[i]);
        end
        w_if.i_Enable = 1'b0;
        chk("n32_done", w_if.o_LFSR_Done, 1'b0);
        chk("hold_zero4", m_if.o_LFSR_Data, 4'h0);

        // N=4 full sequence, two periods
        m_if.i_Enable = 1'b1;
        done_cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            chk($sformatf("seq%0d", i), m_if.o_LFSR_Data, exp4[i % 15]);
            if (m_if.o_LFSR_Done) done_cnt++;
        end
        chk("done_count", 64'(done_cnt), 64'd2);

        // Advance to 0111, then hold with enable low
        repeat (3) cyc();
        chk("pre_hold", m_if.o_LFSR_Data, 4'h7);
        m_if.i_Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("hold%0d", i), m_if.o_LFSR_Data, 4'h7);
            chk($sformatf("hold_done%0d", i), m_if.o_LFSR_Done, 1'b0);
        end
        m_if.i_Seed_Data = 4'h7;
        #1;
        chk("done_comb_hi", m_if.o_LFSR_Done, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("hold_seeddone%0d", i), m_if.o_LFSR_Done, 1'b1);
        end

        // Seed load with enable low, then one step
        m_if.i_Seed_DV   = 1'b1;
        m_if.i_Seed_Data = 4'hA;
        cyc();
        m_if.i_Seed_DV = 1'b0;
        chk("seed_data", m_if.o_LFSR_Data, 4'hA);
        chk("seed_done", m_if.o_LFSR_Done, 1'b1);
        m_if.i_Enable = 1'b1;
        cyc();
        m_if.i_Enable = 1'b0;
        chk("seed_step", m_if.o_LFSR_Data, 4'h4);
        chk("seed_step_done", m_if.o_LFSR_Done, 1'b0);

        // Done follows seed changes in the same cycle
        m_if.i_Seed_Data = 4'h4;
        #1;
        chk("done_comb_match", m_if.o_LFSR_Done, 1'b1);
        m_if.i_Seed_Data = 4'h5;
        #1;
        chk("done_comb_miss", m_if.o_LFSR_Done, 1'b0);

        // Reset beats seed load and enable, mid-sequence
        rst = 1'b1;
        m_if.i_Seed_DV   = 1'b1;
        m_if.i_Seed_Data = 4'h6;
        m_if.i_Enable    = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_over_seed", m_if.o_LFSR_Data, 4'h0);
        chk("rst_over_seed_done", m_if.o_LFSR_Done, 1'b0);

        // Seed beats enable
        m_if.i_Seed_Data = 4'hC;
        cyc();
        chk("seed_over_en", m_if.o_LFSR_Data, 4'hC);

        // Lockup state
        m_if.i_Seed_Data = 4'hF;
        cyc();
        m_if.i_Seed_DV = 1'b0;
        chk("lockup_load", m_if.o_LFSR_Data, 4'hF);
        cyc();
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("lockup_step1", m_if.o_LFSR_Data, 4'h0);
        cyc();
        chk("lockup_step2", m_if.o_LFSR_Data, 4'h1);
`else
        chk("lockup_step1", m_if.o_LFSR_Data, 4'hF);
        cyc();
        chk("lockup_step2", m_if.o_LFSR_Data, 4'hF);
`endif
        m_if.i_Enable = 1'b0;

        // Period walk for N=3..14
        cyc();
        per_rst = 1'b0;
        per_en  = 1'b1;
        @(posedge clk);
        per_run = 1'b1;
        repeat ((1 << 14) + 2) @(negedge clk);
        per_run  = 1'b0;
        per_en   = 1'b0;
        per_done = 1'b1;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
